multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 177 +++++++++++++++++
 tb/tb_multi_cycle_control.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout and bus_error.
// Optional macro JUMP_EN enables the j instruction path (DECODE -> JUMP).
module multi_cycle_control #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_d;
    logic       timeout;
    logic       at_limit;
    logic       in_wait;

    assign state    = state_q;
    assign at_limit = (wait_cnt == LAST_WAIT) && !mem_ready;
    assign in_wait  = (state_q == FETCH) || (state_q == MEMRD) ||
                      (state_q == MEMWR);

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;
        timeout     = 1'b0;
        state_d     = FETCH;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = DECODE;
                else           timeout = at_limit;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
`ifdef JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default:      illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)     state_d = MEMWB;
                else if (at_limit) timeout = 1'b1;
                else               state_d = MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready)     state_d = FETCH;
                else if (at_limit) timeout = 1'b1;
                else               state_d = MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
`ifdef JUMP_EN
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            default: state_d = FETCH;
        endcase
        // Reset holds the FETCH pattern but must not commit anything.
        if (rst) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            illegal_op = 1'b0;
            timeout    = 1'b0;
        end
    end

    assign bus_error = timeout;

    // A state change or timeout re-entry is an entry: the count restarts.
    always_comb begin
        wait_cnt_d = wait_cnt;
        if (timeout || (state_d != state_q))
            wait_cnt_d = 8'd0;
        else if (in_wait && !mem_ready)
            wait_cnt_d = wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            wait_cnt <= 8'd0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: vector table, corner
// sequences and random traffic against an instruction-level model.
module tb_multi_cycle_control;

    localparam int TO = 15;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic       illegal_op, bus_error;
    logic [15:0] ctrl;

    int checks = 0;
    int errors = 0;

    multi_cycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op),
        .bus_error(bus_error)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemToReg,IRWrite,
    //  ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUOp}
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                   MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst,
                   PCSource, ALUSrcB, ALUOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Instruction-level reference model
    int ms;
    int wcnt;
    int route[$];

    function automatic bit is_wait(input int s);
        return s == 0 || s == 3 || s == 5;
    endfunction

    function automatic void plan(input logic [5:0] op, output int r[$]);
        r = {};
        case (op)
            6'b000000: r = {6, 7};
            6'b100011: r = {2, 3, 4};
            6'b101011: r = {2, 5};
            6'b000100: r = {8};
`ifdef JUMP_EN
            6'b000010: r = {9};
`endif
            default:   r = {};
        endcase
    endfunction

    function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
        case (s)
            0:       return mr ? 16'h9204 : 16'h1004;
            1:       return 16'h000C;
            2:       return 16'h0108;
            3:       return 16'h3000;
            4:       return 16'h0480;
            5:       return 16'h2800;
            6:       return 16'h0102;
            7:       return 16'h00C0;
            8:       return 16'h4111;
            9:       return 16'h8020;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic exp_ill(input int s, input logic [5:0] op);
        int r[$];
        plan(op, r);
        return s == 1 && r.size() == 0;
    endfunction

    function automatic logic exp_be(input int s, input logic mr);
        return is_wait(s) && !mr && wcnt == TO - 1;
    endfunction

    task automatic model_edge(input logic [5:0] op, input logic mr);
        int nxt;
        if (is_wait(ms) && !mr) begin
            if (wcnt == TO - 1) begin
                ms = 0;
                wcnt = 0;
                route = {};
            end else begin
                wcnt++;
            end
            return;
        end
        if (ms == 0) begin
            nxt = 1;
        end else begin
            if (ms == 1) plan(op, route);
            nxt = (route.size() > 0) ? route.pop_front() : 0;
        end
        ms = nxt;
        if (is_wait(ms)) wcnt = 0;
    endtask

    int last_state;
    int last_be;
    int last_ill;

    task automatic tick(input logic [5:0] op, input logic mr);
        opcode = op;
        mem_ready = mr;
        #2;
        last_state = int'(state);
        last_be = int'(bus_error);
        last_ill = int'(illegal_op);
        chk("state", int'(state), ms);
        chk("ctrl", int'(ctrl), int'(exp_ctrl(ms, mr)));
        chk("illegal_op", int'(illegal_op), int'(exp_ill(ms, op)));
        chk("bus_error", int'(bus_error), int'(exp_be(ms, mr)));
        @(posedge clk);
        model_edge(op, mr);
        #1;
    endtask

    task automatic do_reset();
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_ctrl", int'(ctrl), 16'h1004);
        chk("rst_err", int'({illegal_op, bus_error}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ms = 0;
        wcnt = 0;
        route = {};
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctl;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n_wr, n_be;
        logic [5:0] op;
        logic mr;

        tbl[0]  = '{6'h00, 1'b1, 4'd0, 16'h9204};
        tbl[1]  = '{6'h00, 1'b1, 4'd1, 16'h000C};
        tbl[2]  = '{6'h00, 1'b1, 4'd6, 16'h0102};
        tbl[3]  = '{6'h00, 1'b1, 4'd7, 16'h00C0};
        tbl[4]  = '{6'h23, 1'b1, 4'd0, 16'h9204};
        tbl[5]  = '{6'h23, 1'b1, 4'd1, 16'h000C};
        tbl[6]  = '{6'h23, 1'b1, 4'd2, 16'h0108};
        tbl[7]  = '{6'h23, 1'b0, 4'd3, 16'h3000};
        tbl[8]  = '{6'h23, 1'b0, 4'd3, 16'h3000};
        tbl[9]  = '{6'h23, 1'b0, 4'd3, 16'h3000};
        tbl[10] = '{6'h23, 1'b1, 4'd3, 16'h3000};
        tbl[11] = '{6'h23, 1'b1, 4'd4, 16'h0480};
        tbl[12] = '{6'h23, 1'b1, 4'd0, 16'h9204};

        rst = 1'b1;
        opcode = 6'h00;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            opcode = tbl[i].op;
            mem_ready = tbl[i].mr;
            #2;
            chk($sformatf("tbl%0d_state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("tbl%0d_ctrl", i), int'(ctrl), int'(tbl[i].ctl));
            chk($sformatf("tbl%0d_err", i),
                int'({illegal_op, bus_error}), 0);
            @(posedge clk);
            #1;
        end

        // sw with memory never ready: full timeout in MEMWR
        do_reset();
        tick(6'h2B, 1'b1);
        tick(6'h2B, 1'b1);
        tick(6'h2B, 1'b1);
        n_wr = 0;
        n_be = 0;
        for (int i = 0; i < TO; i++) begin
            tick(6'h2B, 1'b0);
            n_wr += (last_state == 5) ? 1 : 0;
            n_be += last_be;
        end
        chk("memwr_cycles", n_wr, TO);
        chk("memwr_be_pulses", n_be, 1);
        chk("memwr_after", int'(state), 0);

        // FETCH timeout re-enters FETCH with a fresh count
        n_be = 0;
        for (int i = 0; i < 2 * TO; i++) begin
            tick(6'h00, 1'b0);
            n_be += last_be;
        end
        chk("fetch_be_pulses", n_be, 2);
        chk("fetch_after", int'(state), 0);

        // mem_ready arriving on the limit cycle wins
        tick(6'h23, 1'b1);
        tick(6'h23, 1'b1);
        tick(6'h23, 1'b1);
        for (int i = 0; i < TO - 1; i++) tick(6'h23, 1'b0);
        tick(6'h23, 1'b1);
        chk("late_ready_be", last_be, 0);
        chk("late_ready_state", int'(state), 4);
        tick(6'h23, 1'b1);

        // j opcode
        tick(6'h02, 1'b1);
        tick(6'h02, 1'b1);
`ifdef JUMP_EN
        chk("jump_state", int'(state), 9);
        chk("jump_pcsrc", int'(PCSource), 2);
        tick(6'h02, 1'b1);
        chk("jump_done", int'(state), 0);
`else
        chk("j_illegal", last_ill, 1);
        chk("j_back_fetch", int'(state), 0);
`endif

        // Asynchronous reset while in BRANCH
        tick(6'h04, 1'b1);
        tick(6'h04, 1'b1);
        #1;
        chk("br_pcwc", int'(PCWriteCond), 1);
        rst = 1'b1;
        #1;
        chk("br_rst_pcwc", int'(PCWriteCond), 0);
        chk("br_rst_state", int'(state), 0);
        chk("br_rst_err", int'({illegal_op, bus_error}), 0);
        chk("br_rst_wr", int'({PCWrite, RegWrite, MemWrite}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ms = 0;
        wcnt = 0;
        route = {};

        // Random traffic; opcode only changes while fetching
        op = 6'h00;
        for (int i = 0; i < 4000; i++) begin
            if (ms == 0) begin
                case ($urandom_range(0, 5))
                    0: op = 6'h00;
                    1: op = 6'h23;
                    2: op = 6'h2B;
                    3: op = 6'h04;
                    4: op = 6'h02;
                    default: op = 6'($urandom);
                endcase
            end
            if ((i % 500) >= 200 && (i % 500) < 220) mr = 1'b0;
            else mr = ($urandom_range(0, 99) < 80);
            tick(op, mr);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
